// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment front end: sequential double-dabble binary-to-BCD
// conversion, then a free-running digit scan feeding one shared BCD decoder.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VAL_W-1:0]      value_in,
  input  logic                  load,
  input  logic                  blank_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] digit_en
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                state_q, state_d;
  logic [VAL_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sat_q, sat_d;
  logic [BCD_W-1:0]      digit_q, digit_d;
  logic                  ovf_q, ovf_d;

  logic [REF_W-1:0]      ref_q, ref_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            bcd_out_q;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  logic [BCD_W-1:0]      bcd_adj;
  logic [NUM_DIGITS:0]   zero_from;
  logic                  blank;

  // zero_from[k]: digit k and every digit above it are zero
  assign zero_from[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
    assign zero_from[gi] = zero_from[gi+1] & (digit_q[4*gi +: 4] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      digit_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      digit_q <= digit_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    digit_d = digit_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = value_in;
          bcd_d   = '0;
          cnt_d   = '0;
          sat_d   = 64'(value_in) > MAX_VAL;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        digit_d = sat_q ? {NUM_DIGITS{4'd9}} : bcd_q;
        ovf_d   = sat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == COMMIT);
  assign overflow = ovf_q;

  // Scan runs regardless of conversion activity; output stage is one cycle behind idx_q
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    blank = blank_en && (idx_q != '0) && zero_from[idx_q];
    en_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      idx_q     <= '0;
      bcd_out_q <= 4'd0;
      en_q      <= ~NUM_DIGITS'(1);
    end else begin
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      bcd_out_q <= digit_q[4*idx_q +: 4];
      en_q      <= en_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign digit_en = en_q;

endmodule
